// File: rtl/fma_norm_arb.sv
// Arbiter granting the shared normalization shifter slot to the FMA or div/sqrt requester.
// Define FMA_NORM_ARB_RR_EN for round-robin ties; the default build gives FMA fixed priority.
module fma_norm_arb #(
    parameter int PW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Flush,
    input  logic          FmaValid,
    input  logic [PW-1:0] FmaPayload,
    output logic          FmaReady,
    input  logic          DivValid,
    input  logic [PW-1:0] DivPayload,
    output logic          DivReady,
    output logic          NormValid,
    input  logic          NormReady,
    output logic [PW-1:0] NormPayload,
    output logic          NormSrc
);

    logic slotFree;
    logic canGrant;
    logic fmaWins;

`ifdef FMA_NORM_ARB_RR_EN
    logic rrPtr;
`endif

    assign slotFree = !NormValid || NormReady;
    assign canGrant = !reset && !Flush && slotFree;

`ifdef FMA_NORM_ARB_RR_EN
    // FMA wins when alone or when the pointer favours it on a tie
    assign fmaWins = FmaValid && (!DivValid || !rrPtr);
`else
    assign fmaWins = FmaValid;
`endif

    assign FmaReady = canGrant && fmaWins;
    assign DivReady = canGrant && DivValid && !fmaWins;

    // Flush outranks any load or drain; a grant refills the slot even while it drains
    always_ff @(posedge clk) begin
        if (reset) begin
            NormValid   <= 1'b0;
            NormPayload <= '0;
            NormSrc     <= 1'b0;
        end else if (Flush) begin
            NormValid <= 1'b0;
        end else if (FmaReady) begin
            NormValid   <= 1'b1;
            NormPayload <= FmaPayload;
            NormSrc     <= 1'b0;
        end else if (DivReady) begin
            NormValid   <= 1'b1;
            NormPayload <= DivPayload;
            NormSrc     <= 1'b1;
        end else if (NormReady) begin
            NormValid <= 1'b0;
        end
    end

`ifdef FMA_NORM_ARB_RR_EN
    // After a transfer the pointer favours whichever requester lost
    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr <= 1'b0;
        end else if (FmaReady) begin
            rrPtr <= 1'b1;
        end else if (DivReady) begin
            rrPtr <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fma_norm_arb.sv
// Self-checking bench for fma_norm_arb: vector table plus a payload scoreboard.
// Expected grants follow FMA_NORM_ARB_RR_EN when it is defined.
module tb_fma_norm_arb;

    localparam int PW = 64;

    logic          clk;
    logic          reset;
    logic          Flush;
    logic          FmaValid;
    logic [PW-1:0] FmaPayload;
    logic          FmaReady;
    logic          DivValid;
    logic [PW-1:0] DivPayload;
    logic          DivReady;
    logic          NormValid;
    logic          NormReady;
    logic [PW-1:0] NormPayload;
    logic          NormSrc;

    fma_norm_arb #(.PW(PW)) dut (
        .clk(clk),
        .reset(reset),
        .Flush(Flush),
        .FmaValid(FmaValid),
        .FmaPayload(FmaPayload),
        .FmaReady(FmaReady),
        .DivValid(DivValid),
        .DivPayload(DivPayload),
        .DivReady(DivReady),
        .NormValid(NormValid),
        .NormReady(NormReady),
        .NormPayload(NormPayload),
        .NormSrc(NormSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          flush;
        logic          fv;
        logic [PW-1:0] fp;
        logic          dv;
        logic [PW-1:0] dp;
        logic          nr;
        logic [1:0]    expRr;
        logic [1:0]    expFix;
    } vec_t;

    typedef struct {
        logic [PW-1:0] payload;
        logic          src;
    } exp_t;

    vec_t          vecs[16];
    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    logic          expValid = 1'b0;
    logic [PW-1:0] expPayload = '0;
    logic          expSrc = 1'b0;

    function automatic vec_t mk(string n, logic fl, logic fv, logic [PW-1:0] fp,
                                logic dv, logic [PW-1:0] dp, logic nr,
                                logic [1:0] rr, logic [1:0] fix);
        vec_t v;
        v.name = n; v.flush = fl; v.fv = fv; v.fp = fp; v.dv = dv; v.dp = dp;
        v.nr = nr; v.expRr = rr; v.expFix = fix;
        return v;
    endfunction

    task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name);
        chk({name, " NormValid"}, {63'b0, NormValid}, {63'b0, expValid});
        if (expValid) begin
            chk({name, " NormPayload"}, NormPayload, expPayload);
            chk({name, " NormSrc"}, {63'b0, NormSrc}, {63'b0, expSrc});
        end
    endtask

    // Grants are two-bit {div, fma}; a granted payload is queued until the slot shows it
    task automatic applyStimulus(input vec_t v);
        logic [1:0] expG;
        exp_t       e;
        @(negedge clk);
        Flush = v.flush; FmaValid = v.fv; FmaPayload = v.fp;
        DivValid = v.dv; DivPayload = v.dp; NormReady = v.nr;
        #1;
`ifdef FMA_NORM_ARB_RR_EN
        expG = v.expRr;
`else
        expG = v.expFix;
`endif
        chk({v.name, " grant"}, {62'b0, DivReady, FmaReady}, {62'b0, expG});
        if (expG == 2'b01) sbq.push_back('{v.fp, 1'b0});
        else if (expG == 2'b10) sbq.push_back('{v.dp, 1'b1});
        @(posedge clk);
        #1;
        if (v.flush) begin
            expValid = 1'b0;
        end else if (expG != 2'b00) begin
            if (sbq.size() == 0) begin
                errors++;
                $display("[TB] FAIL %s scoreboard: got empty queue want entry", v.name);
            end else begin
                e = sbq.pop_front();
                expValid = 1'b1; expPayload = e.payload; expSrc = e.src;
            end
        end else if (v.nr) begin
            expValid = 1'b0;
        end
        checkOutput(v.name);
    endtask

    initial begin
        vecs[0]  = mk("fma_first",  0, 1, 64'h1234,           0, 64'h0,              1, 2'b01, 2'b01);
        vecs[1]  = mk("div_lone",   0, 0, 64'h0,              1, 64'hAAAA_0000_0001, 1, 2'b10, 2'b10);
        vecs[2]  = mk("tie_1",      0, 1, 64'hF000_0000_0001, 1, 64'hD000_0000_0001, 1, 2'b01, 2'b01);
        vecs[3]  = mk("tie_2",      0, 1, 64'hF000_0000_0002, 1, 64'hD000_0000_0002, 1, 2'b10, 2'b01);
        vecs[4]  = mk("tie_3",      0, 1, 64'hF000_0000_0003, 1, 64'hD000_0000_0003, 1, 2'b01, 2'b01);
        vecs[5]  = mk("tie_4",      0, 1, 64'hF000_0000_0004, 1, 64'hD000_0000_0004, 1, 2'b10, 2'b01);
        vecs[6]  = mk("drain",      0, 0, 64'h0,              0, 64'h0,              1, 2'b00, 2'b00);
        vecs[7]  = mk("fill_empty", 0, 1, 64'h5555_6666_7777, 0, 64'h0,              0, 2'b01, 2'b01);
        vecs[8]  = mk("stall_1",    0, 1, 64'h0BAD_0001,      1, 64'h0BAD_1001,      0, 2'b00, 2'b00);
        vecs[9]  = mk("stall_2",    0, 1, 64'h0BAD_0002,      1, 64'h0BAD_1002,      0, 2'b00, 2'b00);
        vecs[10] = mk("stall_3",    0, 1, 64'h0BAD_0003,      1, 64'h0BAD_1003,      0, 2'b00, 2'b00);
        vecs[11] = mk("unstall",    0, 1, 64'hC0DE_0001,      1, 64'hC0DE_1001,      1, 2'b10, 2'b01);
        vecs[12] = mk("flush",      1, 0, 64'h0,              1, 64'hDEAD_0000,      0, 2'b00, 2'b00);
        vecs[13] = mk("post_flush", 0, 0, 64'h0,              1, 64'hBEEF_0000,      0, 2'b10, 2'b10);
        vecs[14] = mk("fma_lone_a", 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0,        1, 2'b01, 2'b01);
        vecs[15] = mk("fma_lone_b", 0, 1, 64'h8000_0000_0000_0001, 0, 64'h0,        1, 2'b01, 2'b01);

        reset = 1'b1; Flush = 1'b0; FmaValid = 1'b1; FmaPayload = 64'h99;
        DivValid = 1'b1; DivPayload = 64'h77; NormReady = 1'b1;
        @(negedge clk);
        chk("reset readys", {62'b0, DivReady, FmaReady}, 64'h0);
        @(posedge clk);
        #1;
        chk("reset NormValid", {63'b0, NormValid}, 64'h0);
        chk("reset NormPayload", NormPayload, 64'h0);
        chk("reset NormSrc", {63'b0, NormSrc}, 64'h0);
        @(negedge clk);
        reset = 1'b0; FmaValid = 1'b0; DivValid = 1'b0;

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Reset with a full slot: contents discarded, pointer back to FMA
        @(negedge clk);
        reset = 1'b1; FmaValid = 1'b1; DivValid = 1'b1; NormReady = 1'b0; Flush = 1'b0;
        #1;
        chk("midreset readys", {62'b0, DivReady, FmaReady}, 64'h0);
        @(posedge clk);
        #1;
        expValid = 1'b0;
        sbq.delete();
        chk("midreset NormValid", {63'b0, NormValid}, 64'h0);
        chk("midreset NormPayload", NormPayload, 64'h0);
        chk("midreset NormSrc", {63'b0, NormSrc}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(mk("after_reset_tie", 0, 1, 64'hA5A5, 1, 64'h5A5A, 1, 2'b01, 2'b01));
        applyStimulus(mk("final_drain", 0, 0, 64'h0, 0, 64'h0, 1, 2'b00, 2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
